// File: rtl/tlu_pkg.sv
// Shared types and constants for the TLU trigger scheduler.
// Holds the run-control state encoding and the timeout counter geometry.
package tlu_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_HOLDOFF = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int N_DUT_DEF = 6;
  localparam int TO_CNT_W  = 8;

endpackage

// File: rtl/tlu_sat_counter.sv
// Up-counter with synchronous clear; wraps or sticks at all-ones depending on SAT.
// One-cycle update latency, no backpressure.
module tlu_sat_counter #(
  parameter int W   = 8,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic at_max;

  assign at_max = SAT && (cnt == {W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/tlu_trig_scheduler.sv
// Trigger acceptance sequencer: gates requests on DUT readiness, dead time and trigger limit.
// TRIG_GO follows an accepted TRIG_REQ by one cycle; requests never stall, rejected ones are counted.
module tlu_trig_scheduler
  import tlu_pkg::*;
#(
  parameter int N_DUT  = N_DUT_DEF,
  parameter int DEAD_W = 8,
  parameter int ID_W   = 32
) (
  input  logic                SYS_CLK,
  input  logic                SYS_RST,
  input  logic                START,
  input  logic                STOP,
  input  logic                TRIG_REQ,
  input  logic [N_DUT-1:0]    READY,
  input  logic [N_DUT-1:0]    TIME_OUT,
  input  logic [N_DUT-1:0]    CONF_EN_OUTPUT,
  input  logic [DEAD_W-1:0]   CONF_DEAD_TIME,
  input  logic [ID_W-1:0]     CONF_MAX_TRIG,
  input  logic                CONF_AUTO_DISABLE,
  output logic                TRIG_GO,
  output logic [ID_W-1:0]     TRIG_ID,
  output logic [ID_W-1:0]     SKIP_CNT,
  output logic [TO_CNT_W-1:0] TIMEOUT_CNT,
  output logic [N_DUT-1:0]    ACTIVE_MASK,
  output logic                ARMED,
  output logic                DONE
);

  state_t            state, state_nxt;
  logic [DEAD_W-1:0] dead_cnt;
  logic              all_ready, ctl, start_eff, in_run;
  logic              accept, skip_inc, to_inc;
  logic              go_nxt, armed_nxt, done_nxt;
  logic [ID_W-1:0]   id_now, id_new;

  assign all_ready = &(READY | ~ACTIVE_MASK);
  assign ctl       = START | STOP;
  assign start_eff = START & ~STOP;
  assign in_run    = (state == S_ARMED) || (state == S_HOLDOFF);
  assign accept    = !ctl && (state == S_ARMED) && TRIG_REQ && all_ready;
  assign skip_inc  = !ctl && TRIG_REQ &&
                     (((state == S_ARMED) && !all_ready) || (state == S_HOLDOFF));
  assign to_inc    = !ctl && in_run && |(TIME_OUT & ACTIVE_MASK);

  // TRIG_ID lags by one while TRIG_GO is high, so fold the pending increment in
  // before comparing against the limit; otherwise back-to-back triggers overshoot.
  assign id_now = TRIG_ID + ID_W'(TRIG_GO);
  assign id_new = id_now + ID_W'(1);

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (STOP) begin
      state_nxt = S_IDLE;
    end else if (START) begin
      state_nxt = S_ARMED;
    end else begin
      case (state)
        S_ARMED: begin
          if (TRIG_REQ && all_ready) begin
            if ((CONF_MAX_TRIG != '0) && (id_new == CONF_MAX_TRIG))
              state_nxt = S_DONE;
            else if (CONF_DEAD_TIME != '0)
              state_nxt = S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          if (dead_cnt <= DEAD_W'(1)) state_nxt = S_ARMED;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    go_nxt    = accept;
    armed_nxt = (state_nxt == S_ARMED) || (state_nxt == S_HOLDOFF);
    done_nxt  = (state_nxt == S_DONE);
  end

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      TRIG_GO     <= 1'b0;
      ARMED       <= 1'b0;
      DONE        <= 1'b0;
      TRIG_ID     <= '0;
      ACTIVE_MASK <= '0;
      dead_cnt    <= '0;
    end else begin
      TRIG_GO <= go_nxt;
      ARMED   <= armed_nxt;
      DONE    <= done_nxt;

      if (start_eff)    TRIG_ID <= '0;
      else if (TRIG_GO) TRIG_ID <= TRIG_ID + ID_W'(1);

      if (accept)
        dead_cnt <= CONF_DEAD_TIME;
      else if ((state == S_HOLDOFF) && (dead_cnt != '0))
        dead_cnt <= dead_cnt - DEAD_W'(1);

      if (start_eff)
        ACTIVE_MASK <= CONF_EN_OUTPUT;
      else if (!STOP && in_run && CONF_AUTO_DISABLE)
        ACTIVE_MASK <= ACTIVE_MASK & ~TIME_OUT;
    end
  end

  tlu_sat_counter #(.W(ID_W), .SAT(1'b0)) u_skip_cnt (
    .clk (SYS_CLK),
    .rst (SYS_RST),
    .clr (start_eff),
    .inc (skip_inc),
    .cnt (SKIP_CNT)
  );

  tlu_sat_counter #(.W(TO_CNT_W), .SAT(1'b1)) u_timeout_cnt (
    .clk (SYS_CLK),
    .rst (SYS_RST),
    .clr (start_eff),
    .inc (to_inc),
    .cnt (TIMEOUT_CNT)
  );

endmodule
